// File: rtl/lcd_bus_reader_pkg.sv
// ============================================================================
// lcd_bus_reader_pkg : shared op encodings, default bus timing, FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package lcd_bus_reader_pkg;

   localparam logic [1:0] OP_STATUS    = 2'b00;
   localparam logic [1:0] OP_DATA      = 2'b01;
   localparam logic [1:0] OP_POLL      = 2'b10;
   localparam logic [1:0] OP_POLL_DATA = 2'b11;

   // Default timing in system clock cycles; also consumed by the writer side.
   localparam int unsigned T_AS_DEF     = 8;
   localparam int unsigned T_PW_DEF     = 32;
   localparam int unsigned T_H_DEF      = 8;
   localparam int unsigned T_GAP_DEF    = 64;
   localparam int unsigned T_POLLTO_DEF = 262144;

   localparam int unsigned CNT_W = 24;

   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_SETUP = 2'd1,
      SB_EHIGH = 2'd2,
      SB_HOLD  = 2'd3
   } strb_state_e;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_STRB = 2'd1,
      RD_GAP  = 2'd2,
      RD_DONE = 2'd3
   } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/lcd_rd_strobe.sv
// ============================================================================
// lcd_rd_strobe : one SETUP / E-high / HOLD read strobe with captured byte
// Revision 1.0
// ============================================================================
`default_nettype none

module lcd_rd_strobe
   import lcd_bus_reader_pkg::*;
#(
   parameter int unsigned T_AS = T_AS_DEF,
   parameter int unsigned T_PW = T_PW_DEF,
   parameter int unsigned T_H  = T_H_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_i,
   input  logic       rs_i,
   input  logic [7:0] lcddin_i,
   output logic       done_o,
   output logic       cap_o,
   output logic [7:0] byte_o,
   output logic       rslcd_o,
   output logic       rwlcd_o,
   output logic       elcd_o,
   output logic       lcd_rel_o
);

   strb_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             rs_q, rs_d;
   logic [7:0]       byte_q, byte_d;
   logic             cap_q, cap_d;
   logic             rw_q, e_q, rsl_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      rs_d    = rs_q;
      byte_d  = byte_q;
      cap_d   = 1'b0;
      done_o  = 1'b0;
      unique case (state_q)
         SB_IDLE: begin
            cnt_d = '0;
            if (start_i) begin
               state_d = SB_SETUP;
               rs_d    = rs_i;
            end
         end
         SB_SETUP: begin
            if (cnt_q == CNT_W'(T_AS - 1)) begin
               state_d = SB_EHIGH;
               cnt_d   = '0;
            end
         end
         SB_EHIGH: begin
            if (cnt_q == CNT_W'(T_PW - 1)) begin
               state_d = SB_HOLD;
               cnt_d   = '0;
               byte_d  = lcddin_i;
               cap_d   = 1'b1;
            end
         end
         SB_HOLD: begin
            if (cnt_q == CNT_W'(T_H - 1)) begin
               done_o = 1'b1;
               cnt_d  = '0;
               // A follow-on read may chain straight into SETUP with RW kept high.
               if (start_i) begin
                  state_d = SB_SETUP;
                  rs_d    = rs_i;
               end else begin
                  state_d = SB_IDLE;
               end
            end
         end
         default: begin
            state_d = SB_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Pin drivers are registered from the next state so they toggle glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= SB_IDLE;
         cnt_q   <= '0;
         rs_q    <= 1'b0;
         byte_q  <= 8'h00;
         cap_q   <= 1'b0;
         rw_q    <= 1'b0;
         e_q     <= 1'b0;
         rsl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rs_q    <= rs_d;
         byte_q  <= byte_d;
         cap_q   <= cap_d;
         rw_q    <= (state_d != SB_IDLE);
         e_q     <= (state_d == SB_EHIGH);
         rsl_q   <= (state_d != SB_IDLE) && rs_d;
      end
   end

   assign cap_o     = cap_q;
   assign byte_o    = byte_q;
   assign rslcd_o   = rsl_q;
   assign rwlcd_o   = rw_q;
   assign elcd_o    = e_q;
   assign lcd_rel_o = rw_q;

endmodule

`default_nettype wire

// File: rtl/lcd_bus_reader.sv
// ============================================================================
// lcd_bus_reader : HD44780 read side - status/data reads and busy-flag polling
// Revision 1.0
// ============================================================================
`default_nettype none

module lcd_bus_reader
   import lcd_bus_reader_pkg::*;
#(
   parameter int unsigned T_AS     = T_AS_DEF,
   parameter int unsigned T_PW     = T_PW_DEF,
   parameter int unsigned T_H      = T_H_DEF,
   parameter int unsigned T_GAP    = T_GAP_DEF,
   parameter int unsigned T_POLLTO = T_POLLTO_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rd_start_i,
   input  logic [1:0] rd_op_i,
   output logic       rd_busy_o,
   output logic       rd_done_o,
   output logic [7:0] rd_data_o,
   output logic       bf_o,
   output logic [6:0] ac_o,
   output logic       timeout_o,
   output logic       rslcd_o,
   output logic       rwlcd_o,
   output logic       elcd_o,
   output logic       lcd_rel_o,
   input  logic [7:0] lcddin_i
);

   rd_state_e        state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic             data_ph_q, data_ph_d;
   logic [CNT_W-1:0] tmr_q, tmr_d;
   logic [CNT_W-1:0] gap_q, gap_d;
   logic             timeout_q, timeout_d;
   logic             bf_q, bf_d;
   logic [6:0]       ac_q, ac_d;
   logic [7:0]       data_q, data_d;
   logic             busy_q, done_q;

   logic             strb_start, strb_rs, strb_done, strb_cap;
   logic [7:0]       strb_byte;

   lcd_rd_strobe #(
      .T_AS (T_AS),
      .T_PW (T_PW),
      .T_H  (T_H)
   ) u_strobe (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (strb_start),
      .rs_i      (strb_rs),
      .lcddin_i  (lcddin_i),
      .done_o    (strb_done),
      .cap_o     (strb_cap),
      .byte_o    (strb_byte),
      .rslcd_o   (rslcd_o),
      .rwlcd_o   (rwlcd_o),
      .elcd_o    (elcd_o),
      .lcd_rel_o (lcd_rel_o)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      data_ph_d  = data_ph_q;
      gap_d      = gap_q;
      timeout_d  = timeout_q;
      bf_d       = bf_q;
      ac_d       = ac_q;
      data_d     = data_q;
      strb_start = 1'b0;
      strb_rs    = data_ph_q;
      tmr_d      = (tmr_q == '1) ? tmr_q : tmr_q + CNT_W'(1);

      if (strb_cap) begin
         if (data_ph_q) begin
            data_d = strb_byte;
         end else begin
            bf_d = strb_byte[7];
            ac_d = strb_byte[6:0];
         end
      end

      unique case (state_q)
         RD_IDLE: begin
            tmr_d = '0;
            if (rd_start_i) begin
               op_d       = rd_op_i;
               timeout_d  = 1'b0;
               data_ph_d  = (rd_op_i == OP_DATA);
               strb_start = 1'b1;
               strb_rs    = (rd_op_i == OP_DATA);
               state_d    = RD_STRB;
            end
         end
         RD_STRB: begin
            // Decide on the byte just latched by the strobe, not the bf register.
            if (strb_done) begin
               if (!data_ph_q && op_q[1] && strb_byte[7]) begin
                  state_d = RD_GAP;
                  gap_d   = '0;
               end else if (!data_ph_q && (op_q == OP_POLL_DATA)) begin
                  data_ph_d  = 1'b1;
                  strb_start = 1'b1;
                  strb_rs    = 1'b1;
               end else begin
                  state_d = RD_DONE;
               end
            end
         end
         RD_GAP: begin
            gap_d = gap_q + CNT_W'(1);
            if (tmr_q >= CNT_W'(T_POLLTO - 1)) begin
               timeout_d = 1'b1;
               state_d   = RD_DONE;
            end else if (gap_q == CNT_W'(T_GAP - 1)) begin
               strb_start = 1'b1;
               strb_rs    = 1'b0;
               state_d    = RD_STRB;
            end
         end
         RD_DONE: begin
            state_d = RD_IDLE;
         end
         default: begin
            state_d = RD_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RD_IDLE;
         op_q      <= 2'b00;
         data_ph_q <= 1'b0;
         tmr_q     <= '0;
         gap_q     <= '0;
         timeout_q <= 1'b0;
         bf_q      <= 1'b0;
         ac_q      <= 7'h00;
         data_q    <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         data_ph_q <= data_ph_d;
         tmr_q     <= tmr_d;
         gap_q     <= gap_d;
         timeout_q <= timeout_d;
         bf_q      <= bf_d;
         ac_q      <= ac_d;
         data_q    <= data_d;
         busy_q    <= (state_d != RD_IDLE);
         done_q    <= (state_d == RD_DONE);
      end
   end

   assign rd_busy_o = busy_q;
   assign rd_done_o = done_q;
   assign rd_data_o = data_q;
   assign bf_o      = bf_q;
   assign ac_o      = ac_q;
   assign timeout_o = timeout_q;

endmodule

`default_nettype wire
